// File: rtl/axi_probe_target.sv
// AXI4-Lite register target with a small bank of 32-bit registers, programmable
// response latency and completed-transaction counters.
module axi_probe_target #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned NREGS_LOG2  = 4,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int unsigned NREGS     = 1 << NREGS_LOG2;
  localparam int unsigned LSB       = NREGS_LOG2 + 2;
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;

  wstate_e w_state_q, w_state_d;
  rstate_e r_state_q, r_state_d;

  logic        aw_held_q, aw_held_d;
  logic [31:0] aw_addr_q, aw_addr_d;
  logic        w_held_q, w_held_d;
  logic [31:0] w_data_q, w_data_d;
  logic [3:0]  w_strb_q, w_strb_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic [31:0] ar_addr_q, ar_addr_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] rd_count_q, rd_count_d;

  logic aw_hs, w_hs, wr_commit, rd_load;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;
  logic        wr_hit, rd_hit;
  logic [NREGS_LOG2-1:0] wr_idx, rd_idx;
  logic unused_bits;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  // A beat arriving this cycle is used directly so the zero-wait path commits on the handshake edge.
  assign wr_addr = aw_held_q ? aw_addr_q : s_axi_awaddr;
  assign wr_data = w_held_q ? w_data_q : s_axi_wdata;
  assign wr_strb = w_held_q ? w_strb_q : s_axi_wstrb;
  assign rd_addr = (r_state_q == R_IDLE) ? s_axi_araddr : ar_addr_q;

  assign wr_hit = (wr_addr[31:LSB] == ADDR_BASE[31:LSB]);
  assign rd_hit = (rd_addr[31:LSB] == ADDR_BASE[31:LSB]);
  assign wr_idx = wr_addr[LSB-1:2];
  assign rd_idx = rd_addr[LSB-1:2];

  assign unused_bits = ^{s_axi_awsize, s_axi_arsize, wr_addr[1:0], rd_addr[1:0]};

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      w_cnt_q    <= '0;
      ar_addr_q  <= '0;
      r_cnt_q    <= '0;
      bresp_q    <= '0;
      rresp_q    <= '0;
      rdata_q    <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      w_cnt_q    <= w_cnt_d;
      ar_addr_q  <= ar_addr_d;
      r_cnt_q    <= r_cnt_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin : write_next
    w_state_d  = w_state_q;
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    w_cnt_d    = w_cnt_q;
    bresp_d    = bresp_q;
    wr_count_d = wr_count_q;
    regs_d     = regs_q;
    wr_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axi_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          w_data_d = s_axi_wdata;
          w_strb_d = s_axi_wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (WAIT_CYCLES == 0) begin
            w_state_d = W_RESP;
            wr_commit = 1'b1;
          end else begin
            w_state_d = W_WAIT;
            w_cnt_d   = '0;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == WAIT_LAST) begin
          w_state_d = W_RESP;
          wr_commit = 1'b1;
        end else begin
          w_cnt_d = w_cnt_q + 4'd1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d  = W_IDLE;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_count_d = wr_count_q + 16'd1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (wr_commit) begin
      bresp_d = wr_hit ? RESP_OKAY : RESP_SLVERR;
      if (wr_hit) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin : read_next
    r_state_d  = r_state_q;
    ar_addr_d  = ar_addr_q;
    r_cnt_d    = r_cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_count_d = rd_count_q;
    rd_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          ar_addr_d = s_axi_araddr;
          if (WAIT_CYCLES == 0) begin
            r_state_d = R_RESP;
            rd_load   = 1'b1;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = '0;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == WAIT_LAST) begin
          r_state_d = R_RESP;
          rd_load   = 1'b1;
        end else begin
          r_cnt_d = r_cnt_q + 4'd1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          r_state_d  = R_IDLE;
          rd_count_d = rd_count_q + 16'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Sampling regs_q gives the pre-write value when a write commits on the same edge.
    if (rd_load) begin
      rdata_d = rd_hit ? regs_q[rd_idx] : '0;
      rresp_d = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_comb begin : outputs
    s_axi_awready = (w_state_q == W_IDLE) && !aw_held_q;
    s_axi_wready  = (w_state_q == W_IDLE) && !w_held_q;
    s_axi_bvalid  = (w_state_q == W_RESP);
    s_axi_bresp   = bresp_q;
    s_axi_arready = (r_state_q == R_IDLE);
    s_axi_rvalid  = (r_state_q == R_RESP);
    s_axi_rdata   = rdata_q;
    s_axi_rresp   = rresp_q;
    wr_count      = wr_count_q;
    rd_count      = rd_count_q;
  end

endmodule

// File: doc/axi_probe_target.md
AXI_PROBE_TARGET -- requirements
Module: axi_probe_target

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, base address of the register window.
REQ-002 SHALL have parameter NREGS_LOG2, default 4, log2 of the number of 32-bit registers (16).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, range 0..15, extra cycles between request acceptance and response.
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port m_aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports s_axi_awaddr in 32, s_axi_awsize in 3 (ignored), s_axi_awvalid in 1, s_axi_awready out 1: write address channel.
REQ-007 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1: write data channel.
REQ-008 SHALL have ports s_axi_bvalid out 1, s_axi_bready in 1, s_axi_bresp out 2: write response channel.
REQ-009 SHALL have ports s_axi_araddr in 32, s_axi_arsize in 3 (ignored), s_axi_arvalid in 1, s_axi_arready out 1: read address channel.
REQ-010 SHALL have ports s_axi_rvalid out 1, s_axi_rready in 1, s_axi_rdata out 32, s_axi_rresp out 2: read data channel.
REQ-011 SHALL have ports wr_count out 16, rd_count out 16: completed write / read transactions.

Function
REQ-012 SHALL decode in-range as addr[31:NREGS_LOG2+2] == ADDR_BASE[31:NREGS_LOG2+2]; word index = addr[NREGS_LOG2+1:2]; addr[1:0] ignored.
REQ-013 SHALL accept AW and W independently in either order: awready = write FSM in W_IDLE and no AW held; wready = write FSM in W_IDLE and no W held.
REQ-014 SHALL use write FSM W_IDLE -> W_WAIT once both AW and W are held; W_WAIT counts WAIT_CYCLES, then -> W_RESP. With WAIT_CYCLES=0, W_WAIT is skipped: W_IDLE -> W_RESP directly.
REQ-015 SHALL commit the write on entry to W_RESP: in-range, update byte lanes whose wstrb bit is 1, bresp=2'b00; out-of-range, no register change, bresp=2'b10.
REQ-016 SHALL hold bvalid=1 and bresp stable in W_RESP until bready=1. On that cycle: -> W_IDLE, clear held AW and W, increment wr_count.
REQ-017 SHALL give write latency, WAIT_CYCLES=0, AW and W both in cycle N: register updated and bvalid=1 from cycle N+1.
REQ-018 SHALL use read FSM R_IDLE (arready=1) -> R_WAIT on AR handshake, capturing araddr; R_WAIT counts WAIT_CYCLES, then -> R_RESP. With WAIT_CYCLES=0, R_IDLE -> R_RESP directly.
REQ-019 SHALL load rdata/rresp on entry to R_RESP: in-range, register value and 2'b00; out-of-range, 32'h0 and 2'b10.
REQ-020 SHALL hold rvalid=1 and rdata/rresp stable in R_RESP until rready=1. On that cycle: -> R_IDLE, increment rd_count.
REQ-021 SHALL give read latency, WAIT_CYCLES=0, AR in cycle N: rvalid=1 with data from cycle N+1; next AR accepted no earlier than the cycle after the R handshake.
REQ-022 SHALL run the read and write FSMs concurrently. If a read samples the same register on the same edge a write commits, the read SHALL return the pre-write value.
REQ-023 SHALL tolerate bready/rready tied to bvalid/rvalid: each response completes in one cycle.
REQ-024 SHALL let wr_count and rd_count wrap 16'hFFFF -> 16'h0000.
REQ-025 SHALL never assert bvalid without both AW and W accepted, and never assert more than one outstanding response per channel.

Reset
REQ-026 SHALL, while m_aresetn=0, force: both FSMs idle, held flags cleared, registers 32'h0, counters 0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=1, wready=1, arready=1.
REQ-027 SHALL, on reset assertion mid-transaction, drop bvalid/rvalid asynchronously, discard any pending request and not commit the write.

Verification
REQ-028 SHALL cover: AW+W same cycle, addr 0x4, wdata 0x000000A5, wstrb 4'b0001, bready tied to bvalid -> bvalid one cycle later, bresp 0; then AR 0x4 -> rdata 0x000000A5, rresp 0, wr_count=1, rd_count=1.
REQ-029 SHALL cover: W three cycles before AW, wdata 0xDEADBEEF, wstrb 4'b1111 -> wready=0 after W accepted; bvalid only after AW accepted; readback 0xDEADBEEF.
REQ-030 SHALL cover: write to ADDR_BASE+0x100 (out of range, NREGS_LOG2=4) -> bresp 2'b10, no register changes; read there -> rdata 0, rresp 2'b10.
REQ-031 SHALL cover: WAIT_CYCLES=3, rready held 0 for 5 cycles -> rvalid rises 4 cycles after AR, data stable until rready; arready=0 throughout.
REQ-032 SHALL cover: read and write to reg 2 committing on the same edge, old value 0x11, new value 0x22 -> read returns 0x11, next read 0x22.
REQ-033 SHALL cover: reset pulsed while bvalid=1 -> bvalid=0 immediately, all registers 0, all readies 1 after release.
